// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between a CPU and an IO requester.
// Round-robin arbitration with a bounded hold under contention, registered grant
// decode, and a one-cycle registered read return per requester.
module mem_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
);

    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_IO  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_io_q, last_io_d;  // 1: IO was the last owner to transfer
    logic [AW-1:0] addr_q;
    logic [DW-1:0] d_q;
    logic          cpu_xfer, io_xfer;

    assign cpu_gnt  = (state_q == OWN_CPU);
    assign io_gnt   = (state_q == OWN_IO);
    assign cpu_xfer = cpu_gnt & cpu_req;
    assign io_xfer  = io_gnt & io_req;

    // RAM port mux: driven by the owner only in a transfer cycle, otherwise holds.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_d    = d_q;
        if (cpu_xfer) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_d    = cpu_wdata;
        end else if (io_xfer) begin
            ram_we   = io_we;
            ram_addr = io_addr;
            ram_d    = io_wdata;
        end
    end

    // Arbitration next-state: ownership, hold counter and last owner.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_io_d = last_io_q;
        if (cpu_xfer) last_io_d = 1'b0;
        if (io_xfer)  last_io_d = 1'b1;
        case (state_q)
            OWN_CPU: begin
                if (!cpu_req) begin
                    state_d = io_req ? OWN_IO : IDLE;
                    hold_d  = '0;
                end else if (!io_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = OWN_IO;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            OWN_IO: begin
                if (!io_req) begin
                    state_d = cpu_req ? OWN_CPU : IDLE;
                    hold_d  = '0;
                end else if (!cpu_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = OWN_CPU;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                hold_d = '0;
                if (cpu_req && io_req) state_d = last_io_q ? OWN_CPU : OWN_IO;
                else if (cpu_req)      state_d = OWN_CPU;
                else if (io_req)       state_d = OWN_IO;
                else                   state_d = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            last_io_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_io_q <= last_io_d;
        end
    end

    // Hold the last driven RAM address/data between transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            d_q    <= '0;
        end else if (cpu_xfer || io_xfer) begin
            addr_q <= ram_addr;
            d_q    <= ram_d;
        end
    end

    // Read return: capture ram_q on a granted read, pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            io_rvalid  <= 1'b0;
            io_rdata   <= '0;
        end else begin
            cpu_rvalid <= cpu_xfer & ~cpu_we;
            io_rvalid  <= io_xfer & ~io_we;
            if (cpu_xfer && !cpu_we) cpu_rdata <= ram_q;
            if (io_xfer && !io_we)   io_rdata  <= ram_q;
        end
    end

endmodule
